// File: rtl/cond_exec_stage_if.sv
// Decode-to-execute control bundle for cond_exec_stage: D-stage controls and
// hazard/ALU inputs towards the stage, gated E-stage controls and flags back.
interface cond_exec_stage_if #(
  parameter int unsigned ALUCTL_W = 4
);
  logic                PCSrcD;
  logic                BranchD;
  logic                RegWriteD;
  logic                MemWriteD;
  logic                MemtoRegD;
  logic [ALUCTL_W-1:0] ALUControlD;
  logic                ALUSrcD;
  logic [1:0]          FlagWriteD;
  logic [3:0]          CondD;
  logic                StallE;
  logic                FlushE;
  logic [3:0]          ALUFlags;

  logic [ALUCTL_W-1:0] ALUControlE;
  logic                ALUSrcE;
  logic                MemtoRegE;
  logic                RegWriteE;
  logic                MemWriteE;
  logic                PCSrcE;
  logic                CondExE;
  logic [3:0]          Flags;

  modport master (
    output PCSrcD, BranchD, RegWriteD, MemWriteD, MemtoRegD, ALUControlD,
           ALUSrcD, FlagWriteD, CondD, StallE, FlushE, ALUFlags,
    input  ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE, PCSrcE,
           CondExE, Flags
  );

  modport slave (
    input  PCSrcD, BranchD, RegWriteD, MemWriteD, MemtoRegD, ALUControlD,
           ALUSrcD, FlagWriteD, CondD, StallE, FlushE, ALUFlags,
    output ALUControlE, ALUSrcE, MemtoRegE, RegWriteE, MemWriteE, PCSrcE,
           CondExE, Flags
  );
endinterface

// File: rtl/cond_exec_stage.sv
// ID/EX control register plus NZCV flag register; evaluates the ARM condition
// field and gates every state-changing control output of the Execute stage.
module cond_exec_stage #(
  parameter int unsigned ALUCTL_W = 4,
  parameter logic [3:0]  COND_AL  = 4'b1110
) (
  input  logic            clk,
  input  logic            reset,
  cond_exec_stage_if.slave bus
);

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                mem_to_reg;
    logic                pc_src;
    logic                branch;
    logic [1:0]          flag_write;
    logic                alu_src;
    logic [ALUCTL_W-1:0] alu_ctl;
    cond_t               cond;
  } ectl_t;

  ectl_t      e_q, e_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= '0;
      e_q.cond <= cond_t'(COND_AL);
      flags_q  <= '0;
    end else begin
      e_q      <= e_d;
      flags_q  <= flags_d;
    end
  end

  // A bubble carries no enables and an always-true condition.
  always_comb begin
    e_d = e_q;
    if (bus.FlushE) begin
      e_d      = '0;
      e_d.cond = cond_t'(COND_AL);
    end else if (!bus.StallE) begin
      e_d.reg_write  = bus.RegWriteD;
      e_d.mem_write  = bus.MemWriteD;
      e_d.mem_to_reg = bus.MemtoRegD;
      e_d.pc_src     = bus.PCSrcD;
      e_d.branch     = bus.BranchD;
      e_d.flag_write = bus.FlagWriteD;
      e_d.alu_src    = bus.ALUSrcD;
      e_d.alu_ctl    = bus.ALUControlD;
      e_d.cond       = cond_t'(bus.CondD);
    end
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b1;
    unique case (e_q.cond)
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c & !z;
      LS: cond_ex = !c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = !z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b1;
    endcase
  end

  // Flags commit from the outgoing instruction regardless of stall or flush.
  always_comb begin
    flags_d = flags_q;
    if (e_q.flag_write[1] && cond_ex) flags_d[3:2] = bus.ALUFlags[3:2];
    if (e_q.flag_write[0] && cond_ex) flags_d[1:0] = bus.ALUFlags[1:0];
  end

  assign bus.ALUControlE = e_q.alu_ctl;
  assign bus.ALUSrcE     = e_q.alu_src;
  assign bus.MemtoRegE   = e_q.mem_to_reg;
  assign bus.RegWriteE   = e_q.reg_write & cond_ex;
  assign bus.MemWriteE   = e_q.mem_write & cond_ex;
  assign bus.PCSrcE      = (e_q.pc_src | e_q.branch) & cond_ex;
  assign bus.CondExE     = cond_ex;
  assign bus.Flags       = flags_q;

endmodule
